// File: rtl/fetch_buf_pkg.sv
// Shared types and helpers for the fetch_buf instruction-fetch front end.
package fetch_buf_pkg;

   localparam logic [63:0] FB_RESET_PC = 64'h0;

   // Occupancy counters must be able to hold the value DEPTH itself.
   function automatic int fb_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fb_entry32_t;

endpackage

// File: rtl/fetch_buf_fifo.sv
// Generic synchronous FIFO: push/pop/clear, occupancy count and a head
// output read straight from storage (no input-to-output combinational path).
module fetch_buf_fifo
   import fetch_buf_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = fb_cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [CW-1:0] count_o,
   output logic [W-1:0]  head_o
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [CW-1:0] cnt_q;
   logic          do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + PW'(1);
         if (do_pop) rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
      end
   end

   // Storage is zeroed on reset so the head output reads 0 out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i && !clear_i) begin
         mem_q[wr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !clear_i) begin
         assert (!(push_i && !do_pop && cnt_q == CW'(DEPTH)));
      end
   end

endmodule

// File: rtl/fetch_buf.sv
// Instruction-fetch front end: PC generation, pipelined memory requests,
// response buffering and redirect/flush. Optional FETCH_BUF_PERF_EN adds counters.
module fetch_buf
   import fetch_buf_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FB_RESET_PC),
   parameter int                PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic              o_rom_req,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic              i_rom_gnt,
   input  logic              i_rom_rvalid,
   input  logic [DATA_W-1:0] i_rom_rdata,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   input  logic              i_id_stall,
   output logic              o_id_valid,
   output logic [ADDR_W-1:0] o_id_pc,
   output logic [DATA_W-1:0] o_id_inst
`ifdef FETCH_BUF_PERF_EN
   ,
   output logic [31:0]       o_perf_stall_cycles,
   output logic [31:0]       o_perf_drop_cnt
`endif
);

   localparam int                CW   = fb_cnt_w(DEPTH);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] inst;
   } entry_t;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_buf: DEPTH must be a power of 2 and >= 2");
   end

   logic [ADDR_W-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0]     out_q, out_d, drop_q, drop_d, count;
   logic              issue, push, pop;
   entry_t            wentry, head;

   // Credit check counts both buffered and in-flight entries so a push never hits a full FIFO.
   assign o_rom_req  = !rst && !i_redirect &&
                       (({1'b0, count} + {1'b0, out_q}) < (CW+1)'(DEPTH));
   assign o_rom_addr = pc_q;
   assign issue      = o_rom_req && i_rom_gnt;
   assign pop        = (count != '0) && !i_id_stall && !i_redirect;
   assign wentry     = '{pc: resp_pc_q, inst: i_rom_rdata};

   always_comb begin
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      out_d     = out_q;
      drop_d    = drop_q;
      push      = 1'b0;
      if (i_redirect) begin
         // Everything still in flight after this cycle belongs to the old stream.
         pc_d      = i_redirect_pc;
         resp_pc_d = i_redirect_pc;
         out_d     = out_q - CW'(i_rom_rvalid);
         drop_d    = out_d;
      end else begin
         if (issue) pc_d = pc_q + STEP;
         out_d = out_q + CW'(issue) - CW'(i_rom_rvalid);
         if (i_rom_rvalid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CW'(1);
            end else begin
               push      = 1'b1;
               resp_pc_d = resp_pc_q + STEP;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         out_q     <= '0;
         drop_q    <= '0;
      end else begin
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         out_q     <= out_d;
         drop_q    <= drop_d;
      end
   end

   fetch_buf_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (i_redirect),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wentry),
      .count_o (count),
      .head_o  (head)
   );

   assign o_id_valid = (count != '0);
   assign o_id_pc    = head.pc;
   assign o_id_inst  = head.inst;

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(i_rom_rvalid && out_q == '0));
      end
   end

`ifdef FETCH_BUF_PERF_EN
   logic [31:0] stall_cyc_q, drop_cnt_q;
   logic        dropped;

   assign dropped = i_rom_rvalid && (i_redirect || drop_q != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cyc_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (o_id_valid && i_id_stall && stall_cyc_q != '1) stall_cyc_q <= stall_cyc_q + 32'd1;
         if (dropped && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
      end
   end

   assign o_perf_stall_cycles = stall_cyc_q;
   assign o_perf_drop_cnt     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_buf.sv
// Randomized bench for fetch_buf against a queue-based model of fetch stream,
// in-flight requests (with stale marking on redirect) and the decode buffer.
module tb_fetch_buf;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, i_rom_gnt, i_rom_rvalid, i_redirect, i_id_stall;
   logic [31:0] i_rom_rdata, i_redirect_pc;
   logic        o_rom_req, o_id_valid;
   logic [31:0] o_rom_addr, o_id_pc, o_id_inst;
`ifdef FETCH_BUF_PERF_EN
   logic [31:0] o_perf_stall_cycles, o_perf_drop_cnt;
   int          m_stall, m_drop;
`endif

   always #5 clk = ~clk;

   fetch_buf #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .o_rom_req     (o_rom_req),
      .o_rom_addr    (o_rom_addr),
      .i_rom_gnt     (i_rom_gnt),
      .i_rom_rvalid  (i_rom_rvalid),
      .i_rom_rdata   (i_rom_rdata),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_id_stall    (i_id_stall),
      .o_id_valid    (o_id_valid),
      .o_id_pc       (o_id_pc),
      .o_id_inst     (o_id_inst)
`ifdef FETCH_BUF_PERF_EN
      ,
      .o_perf_stall_cycles (o_perf_stall_cycles),
      .o_perf_drop_cnt     (o_perf_drop_cnt)
`endif
   );

   typedef struct { logic [31:0] addr; int due; bit stale; } fl_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

   fl_t         fl[$];   // requests granted, awaiting response, oldest first
   ent_t        fq[$];   // what decode should see, head first
   logic [31:0] pc_m;
   int          cyc, last_due;
   int          total = 0, bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         if (bad <= 30) $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic step(input int pg, input int ps, input int lmin, input int lmax, input int pr,
                       input bit frc_redir, input logic [31:0] frc_pc, input bit frc_rst);
      bit   req_e, rv;
      int   due;
      fl_t  f;
      ent_t e;
      @(posedge clk);
      #1;
      cyc++;
      rst           = frc_rst;
      i_redirect    = frc_redir || ($urandom_range(99) < pr);
      i_redirect_pc = frc_redir ? frc_pc : ($urandom & 32'hFFFF_FFFC);
      i_id_stall    = ($urandom_range(99) < ps);
      i_rom_gnt     = ($urandom_range(99) < pg);
      rv            = !rst && fl.size() > 0 && fl[0].due <= cyc;
      i_rom_rvalid  = rv;
      i_rom_rdata   = rv ? memf(fl[0].addr) : $urandom;
      #4;
      req_e = !rst && !i_redirect && (fq.size() + fl.size() < DEPTH);
      chk("rom_req", {63'd0, o_rom_req}, {63'd0, req_e});
      chk("rom_addr", {32'd0, o_rom_addr}, {32'd0, pc_m});
      chk("id_valid", {63'd0, o_id_valid}, {63'd0, fq.size() != 0});
      if (fq.size() != 0) begin
         chk("id_pc", {32'd0, o_id_pc}, {32'd0, fq[0].pc});
         chk("id_inst", {32'd0, o_id_inst}, {32'd0, fq[0].inst});
      end
`ifdef FETCH_BUF_PERF_EN
      chk("perf_stall", {32'd0, o_perf_stall_cycles}, 64'(m_stall));
      chk("perf_drop", {32'd0, o_perf_drop_cnt}, 64'(m_drop));
`endif
      if (rst) begin
         fl.delete();
         fq.delete();
         pc_m     = 32'h0;
         last_due = cyc;
`ifdef FETCH_BUF_PERF_EN
         m_stall = 0;
         m_drop  = 0;
`endif
      end else begin
`ifdef FETCH_BUF_PERF_EN
         if (fq.size() != 0 && i_id_stall) m_stall++;
         if (rv && (i_redirect || fl[0].stale)) m_drop++;
`endif
         if (i_redirect) begin
            if (rv) void'(fl.pop_front());
            foreach (fl[i]) fl[i].stale = 1'b1;
            fq.delete();
            pc_m = i_redirect_pc;
         end else begin
            if (fq.size() != 0 && !i_id_stall) void'(fq.pop_front());
            if (rv) begin
               f = fl.pop_front();
               if (!f.stale) begin
                  e.pc   = f.addr;
                  e.inst = memf(f.addr);
                  fq.push_back(e);
               end
            end
            if (req_e && i_rom_gnt) begin
               due = cyc + $urandom_range(lmax, lmin);
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               f.addr   = pc_m;
               f.due    = due;
               f.stale  = 1'b0;
               fl.push_back(f);
               pc_m = pc_m + 32'd4;
            end
         end
      end
   endtask

   // Phases: grant%, stall%, latency min/max, redirect%, cycles, forced redirect cycle/pc, reset cycle
   int          P_G  [8] = '{100, 100, 100, 100,   0, 100,   70,   80};
   int          P_S  [8] = '{  0, 100,   0,   0,   0,   0,   40,   30};
   int          P_LO [8] = '{  1,   1,   1,   3,   1,   1,    1,    1};
   int          P_HI [8] = '{  1,   1,   1,   3,   1,   1,    4,    3};
   int          P_R  [8] = '{  0,   0,   0,   0,   0,   0,    4,    3};
   int          P_N  [8] = '{ 30,  12,  10,  14,   5,  15, 2000, 1000};
   int          P_FR [8] = '{ -1,  -1,  -1,   6,  -1,   0,   -1,   -1};
   logic [31:0] P_PC [8] = '{0, 0, 0, 32'h100, 0, 32'hFFFF_FFF4, 0, 0};
   int          P_RS [8] = '{ -1,  -1,  -1,  -1,  -1,  -1,   -1,  500};

   initial begin
      rst = 1'b1; i_rom_gnt = 1'b0; i_rom_rvalid = 1'b0; i_rom_rdata = '0;
      i_redirect = 1'b0; i_redirect_pc = '0; i_id_stall = 1'b0;
`ifdef FETCH_BUF_PERF_EN
      m_stall = 0; m_drop = 0;
`endif
      cyc = 0; last_due = 0; pc_m = 32'h0;
      repeat (2) @(posedge clk);
      #5;
      chk("rst_req", {63'd0, o_rom_req}, 64'd0);
      chk("rst_valid", {63'd0, o_id_valid}, 64'd0);
      chk("rst_addr", {32'd0, o_rom_addr}, 64'd0);
      chk("rst_pc", {32'd0, o_id_pc}, 64'd0);
      chk("rst_inst", {32'd0, o_id_inst}, 64'd0);
      for (int p = 0; p < 8; p++) begin
         for (int c = 0; c < P_N[p]; c++) begin
            step(P_G[p], P_S[p], P_LO[p], P_HI[p], P_R[p],
                 c == P_FR[p], P_PC[p], c == P_RS[p]);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_buf.md
Name: fetch_buf

Overview:
- Parametrised instruction-fetch front end; successor to the fixed pc_reg + if_id pair.
- Generates PCs and issues pipelined requests to an instruction memory with variable, in-order response latency.
- Buffers returned instructions in a DEPTH-entry FIFO and presents {pc, inst} to decode with a valid/stall handshake.
- Supports branch redirect with flush and discard of in-flight responses.

Parameters:
- ADDR_W, 32: PC / instruction-address width.
- DATA_W, 32: instruction width.
- DEPTH, 4: FIFO entries; power of 2, >= 2; also the cap on buffered + outstanding requests.
- RESET_PC, 0: PC value after reset.
- PC_STEP, 4: byte increment per fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- o_rom_req  out  1  fetch request valid.
- o_rom_addr  out  ADDR_W  fetch address (current PC).
- i_rom_gnt  in  1  request accepted this cycle when o_rom_req=1.
- i_rom_rvalid  in  1  response valid; responses arrive in request order.
- i_rom_rdata  in  DATA_W  response instruction.
- i_redirect  in  1  flush and restart fetch.
- i_redirect_pc  in  ADDR_W  new fetch PC, used as-is.
- i_id_stall  in  1  decode cannot accept this cycle.
- o_id_valid  out  1  head entry valid.
- o_id_pc  out  ADDR_W  PC of head entry.
- o_id_inst  out  DATA_W  instruction of head entry.

Behaviour:
- Reset values:
  - pc = resp_pc = RESET_PC.
  - count = outstanding = drop = 0.
  - o_rom_req = 0, o_id_valid = 0, o_id_pc = 0, o_id_inst = 0.
- Counter widths: count, outstanding and drop are $clog2(DEPTH+1) bits.
- Request issue:
  - o_rom_req = !rst && !i_redirect && (count + outstanding < DEPTH).
  - o_rom_addr = pc.
  - On o_rom_req && i_rom_gnt: pc += PC_STEP (wraps mod 2^ADDR_W) and outstanding++.
  - o_rom_addr holds stable while o_rom_req is high and i_rom_gnt is low.
- Response handling, on i_rom_rvalid:
  - outstanding-- in all cases.
  - If drop > 0: drop--, data discarded, resp_pc unchanged.
  - Else: push {resp_pc, i_rom_rdata} into the FIFO and resp_pc += PC_STEP.
  - Issue and retire in the same cycle leave outstanding unchanged.
- Credit rule: count + outstanding <= DEPTH at all times, so a push never meets a full FIFO. Overflow is an assertion failure.
- Output:
  - o_id_valid = (count != 0); o_id_pc and o_id_inst come from the head storage register, with no combinational path from any input.
  - Pop when o_id_valid && !i_id_stall.
  - Push and pop in the same cycle leave count unchanged; pop on empty is a no-op.
  - Latency: response in cycle N is visible on o_id_* in cycle N+1. Minimum request-to-decode latency is 2 cycles with single-cycle memory.
- Redirect (highest priority; overrides push and pop that cycle):
  - FIFO cleared: count = 0, pointers reset.
  - pc and resp_pc are set to i_redirect_pc.
  - drop = outstanding - i_rom_rvalid, i.e. every request still in flight after this cycle. The response arriving in the redirect cycle is discarded and any prior drop is subsumed.
  - o_rom_req = 0 in the redirect cycle; fetching from i_redirect_pc starts in the next cycle.
  - Back-to-back redirects: the last one wins.
- Stall: while i_id_stall is held, the FIFO fills to DEPTH and then requests stop. Nothing is lost and order is preserved.
- Reset mid-operation: all state returns to reset values. Responses arriving after reset are protocol violations; memory must be reset together with this block.
- Assertions:
  - i_rom_rvalid with outstanding == 0.
  - FIFO overflow.
  - DEPTH not a power of 2.

Optional Feature:
- Macro FETCH_BUF_PERF_EN.
- When defined, adds two 32-bit saturating outputs, both reset to 0:
  - o_perf_stall_cycles: increments each cycle with o_id_valid && i_id_stall.
  - o_perf_drop_cnt: increments per discarded response.
- When undefined, these ports and counters do not exist; functional behaviour is identical.

Decomposition:
- Package fetch_buf_pkg:
  - Parameterised entry struct typedef {pc, inst}.
  - Function for counter width.
  - Constant for default RESET_PC.
- Sub-module fetch_buf_fifo: generic synchronous FIFO with push, pop, clear, count, and registered head output, instantiated once.

Test Plan:
- Reset release with 1-cycle memory and no stall: requests issue at 0x0, 0x4, 0x8, …; o_id_valid rises 2 cycles after the first grant; o_id_pc sequence is 0x0, 0x4, 0x8.
- i_id_stall held for 10 cycles with DEPTH=4: exactly 4 entries buffered, o_rom_req low; on release, 4 consecutive pops of 0x0 through 0xC in order.
- Redirect to 0x100 with 3 requests outstanding and 3-cycle latency: the 3 late responses are dropped (o_perf_drop_cnt=3 when enabled); first o_id_pc after the redirect is 0x100.
- Redirect in the same cycle as i_rom_rvalid and a pop: FIFO empties, the response is discarded, drop = outstanding-1, next request address is i_redirect_pc.
- i_rom_gnt low for 5 cycles: o_rom_addr holds 0x8 unchanged; pc advances only on grant.
- PC wrap: RESET_PC = 0xFFFFFFFC gives fetch addresses 0xFFFFFFFC then 0x00000000, and o_id_pc matches.
